// File: rtl/matrix_framebuffer.sv
// Double-buffered RGB pixel store: UART bytes -> back bank, scan driver reads front bank; swap at frame boundary.
// Read latency 1 cycle; rx_ready low while a finished frame waits for its swap.
// Optional MATRIX_FB_GAMMA_EN routes every accepted byte through a gamma-2.2 LUT.
module matrix_framebuffer #(
    parameter int length   = 32,
    parameter int addr_bit = 5,
    parameter int scan_bit = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid,
    output logic                rx_ready,
    input  logic                rx_start,
    input  logic [scan_bit-1:0] row,
    input  logic [addr_bit-1:0] addr,
    output logic [23:0]         data1,
    output logic [23:0]         data2,
    output logic                frame_swap
);

    localparam int ROWS = 2**scan_bit;
    localparam int HALF = ROWS * length;
    localparam int IW   = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [scan_bit-1:0] LAST_ROW = scan_bit'(ROWS - 1);
    localparam logic [IW-1:0]       LAST_IDX = IW'(HALF - 1);

    logic [23:0] mem_up [0:1][0:HALF-1];
    logic [23:0] mem_lo [0:1][0:HALF-1];

    logic                disp_bank;
    logic                pending;
    logic [1:0]          phase;
    logic [7:0]          r_hold;
    logic [7:0]          g_hold;
    logic                whalf;
    logic [IW-1:0]       widx;
    logic [scan_bit-1:0] prev_row;

    logic          accept;
    logic [1:0]    eff_phase;
    logic          wr_en;
    logic          swap;
    logic          rd_bank;
    logic          rd_ok;
    logic [IW-1:0] rd_idx;
    logic [7:0]    byte_in;

`ifdef MATRIX_FB_GAMMA_EN
    function automatic logic [7:0] gamma_val(input int x);
        real v;
        v = 255.0 * ((real'(x) / 255.0) ** 2.2);
        return 8'($rtoi(v + 0.5));
    endfunction

    logic [7:0] gamma_lut [0:255];
    for (genvar i = 0; i < 256; i++) begin : g_lut
        localparam logic [7:0] GV = gamma_val(i);
        assign gamma_lut[i] = GV;
    end
    assign byte_in = gamma_lut[rx_data];
`else
    assign byte_in = rx_data;
`endif

    assign rx_ready   = !reset && !pending;
    assign accept     = rx_valid && rx_ready;
    // rx_start in the same cycle as a byte makes that byte the R of pixel 0
    assign eff_phase  = rx_start ? 2'd0 : phase;
    assign wr_en      = accept && (eff_phase == 2'd2);
    assign swap       = !reset && pending && (prev_row == LAST_ROW) && (row == '0);
    assign frame_swap = swap;
    // a read issued in the swap cycle already sees the new front bank
    assign rd_bank    = disp_bank ^ swap;
    assign rd_ok      = 32'(addr) < length;
    assign rd_idx     = IW'(row) * IW'(length) + IW'(addr);

    always_ff @(posedge clk) begin
        if (reset) begin
            disp_bank <= 1'b0;
            pending   <= 1'b0;
            phase     <= 2'd0;
            r_hold    <= 8'd0;
            g_hold    <= 8'd0;
            whalf     <= 1'b0;
            widx      <= '0;
            prev_row  <= '0;
        end else begin
            prev_row <= row;
            if (swap) begin
                disp_bank <= ~disp_bank;
                pending   <= 1'b0;
            end
            if (rx_start) begin
                phase <= 2'd0;
                whalf <= 1'b0;
                widx  <= '0;
            end
            if (accept) begin
                case (eff_phase)
                    2'd0: begin
                        r_hold <= byte_in;
                        phase  <= 2'd1;
                    end
                    2'd1: begin
                        g_hold <= byte_in;
                        phase  <= 2'd2;
                    end
                    default: begin
                        phase <= 2'd0;
                        if (widx == LAST_IDX) begin
                            widx  <= '0;
                            whalf <= ~whalf;
                            if (whalf) pending <= 1'b1;
                        end else begin
                            widx <= widx + 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    // pixel storage has no reset; only the back bank is ever written
    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (!whalf) mem_up[~disp_bank][widx] <= {r_hold, g_hold, byte_in};
            else        mem_lo[~disp_bank][widx] <= {r_hold, g_hold, byte_in};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data1 <= 24'h000000;
            data2 <= 24'h000000;
        end else if (rd_ok) begin
            data1 <= mem_up[rd_bank][rd_idx];
            data2 <= mem_lo[rd_bank][rd_idx];
        end else begin
            data1 <= 24'h000000;
            data2 <= 24'h000000;
        end
    end

endmodule

// File: tb/tb_matrix_framebuffer.sv
// Scoreboard bench for matrix_framebuffer with length=5, scan_bit=2 (40 pixels per frame).
module tb_matrix_framebuffer;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        rx_start;
    logic [1:0]  row;
    logic [4:0]  addr;
    logic [23:0] data1;
    logic [23:0] data2;
    logic        frame_swap;

    always #5 clk = ~clk;

    matrix_framebuffer #(.length(5), .addr_bit(5), .scan_bit(2)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .rx_start(rx_start), .row(row), .addr(addr),
        .data1(data1), .data2(data2), .frame_swap(frame_swap)
    );

    typedef struct packed {
        logic        care;
        logic [23:0] e1;
        logic [23:0] e2;
    } rd_t;

    rd_t         sbq[$];
    int          total = 0;
    int          bad   = 0;
    logic [23:0] mmem   [0:1][0:39];
    bit          mknown [0:1][0:39];
    logic        mbank;
    logic        mpend;
    int          mptr;
    int          mphase;
    logic [7:0]  mr;
    logic [7:0]  mg;
    logic [1:0]  mprev;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gm(input logic [7:0] x);
`ifdef MATRIX_FB_GAMMA_EN
        return 8'($rtoi(255.0 * ((real'(x) / 255.0) ** 2.2) + 0.5));
`else
        return x;
`endif
    endfunction

    function automatic logic [23:0] pix(input int k, input int n);
        logic [7:0] nb;
        nb = 8'(n);
        case (k)
            1:       return {nb, 8'hA5, ~nb};
            2:       return {nb + 8'd100, 8'h5A, nb};
            3:       return {nb + 8'd50, 8'hC3, nb << 1};
            4:       return {nb * 8'd3, 8'h3C, nb ^ 8'h55};
            default: return {(n == 0) ? 8'd128 : nb + 8'd1, 8'h80, 8'hFF};
        endcase
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset;
        mbank = 1'b0; mpend = 1'b0; mptr = 0; mphase = 0; mprev = 2'd0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit start);
        int w;
        rx_data = b; rx_valid = 1'b1; rx_start = start; w = 0;
        while (!rx_ready && w < 200) begin
            tick;
            w++;
        end
        if (!rx_ready) begin
            chk("rx_ready_wait", 32'(rx_ready), 32'd1);
            rx_valid = 1'b0; rx_start = 1'b0;
            return;
        end
        if (start) begin
            mphase = 0; mptr = 0;
        end
        case (mphase)
            0: begin mr = gm(b); mphase = 1; end
            1: begin mg = gm(b); mphase = 2; end
            default: begin
                mmem[~mbank][mptr]   = {mr, mg, gm(b)};
                mknown[~mbank][mptr] = 1'b1;
                mphase = 0;
                mptr++;
                if (mptr == 40) begin
                    mptr  = 0;
                    mpend = 1'b1;
                end
            end
        endcase
        tick;
        rx_valid = 1'b0; rx_start = 1'b0;
    endtask

    task automatic send_frame(input int k, input bit restart);
        logic [23:0] p;
        for (int n = 0; n < 40; n++) begin
            p = pix(k, n);
            if (restart && n == 0) send_byte(8'h11, 1'b1);
            else                   send_byte(p[23:16], 1'b0);
            send_byte(p[15:8], 1'b0);
            send_byte(p[7:0], 1'b0);
        end
    endtask

    task automatic rd(input logic [1:0] r, input logic [4:0] a);
        rd_t it;
        bit  sw;
        int  i;
        row = r; addr = a;
        #1;
        sw = mpend && (mprev == 2'd3) && (r == 2'd0);
        chk($sformatf("frame_swap r%0d a%0d", r, a), 32'(frame_swap), 32'(sw));
        if (sw) begin
            mbank = ~mbank;
            mpend = 1'b0;
        end
        if (a >= 5) begin
            it.care = 1'b1; it.e1 = 24'h0; it.e2 = 24'h0;
        end else begin
            i = int'(r) * 5 + int'(a);
            it.care = mknown[mbank][i] && mknown[mbank][i + 20];
            it.e1   = mmem[mbank][i];
            it.e2   = mmem[mbank][i + 20];
        end
        sbq.push_back(it);
        mprev = r;
        tick;
        it = sbq.pop_front();
        if (it.care) begin
            chk($sformatf("data1 r%0d a%0d", r, a), 32'(data1), 32'(it.e1));
            chk($sformatf("data2 r%0d a%0d", r, a), 32'(data2), 32'(it.e2));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cnt;
        for (int b = 0; b < 2; b++)
            for (int n = 0; n < 40; n++) mknown[b][n] = 1'b0;
        reset = 1'b1; rx_valid = 1'b0; rx_start = 1'b0; rx_data = 8'h00;
        row = 2'd0; addr = 5'd0;
        model_reset;
        tick; tick;
        chk("reset data1", 32'(data1), 32'd0);
        chk("reset data2", 32'(data2), 32'd0);
        chk("reset frame_swap", 32'(frame_swap), 32'd0);
        chk("reset rx_ready", 32'(rx_ready), 32'd0);
        reset = 1'b0;
        #1;
        chk("rx_ready after reset", 32'(rx_ready), 32'd1);

        // first frame, then a 3 -> 0 row transition
        send_frame(1, 1'b0);
        chk("rx_ready frame done", 32'(rx_ready), 32'd0);
        rd(2'd3, 5'd0);
        rd(2'd0, 5'd0);
        rd(2'd1, 5'd2);
        chk("px7 data1", 32'(data1), 32'({gm(8'd7), gm(8'hA5), gm(8'hF8)}));
        chk("px27 data2", 32'(data2), 32'({gm(8'd27), gm(8'hA5), gm(8'hE4)}));

        // pending frame blocks the byte stream
        send_frame(2, 1'b0);
        rx_data = 8'hEE; rx_valid = 1'b1; cnt = 0;
        repeat (20) begin
            if (rx_ready) cnt++;
            tick;
        end
        rx_valid = 1'b0;
        chk("held accepts", 32'(cnt), 32'd0);
        rd(2'd1, 5'd2);
        rd(2'd3, 5'd4);
        rd(2'd0, 5'd0);
        rd(2'd2, 5'd3);
        send_frame(3, 1'b0);
        rd(2'd1, 5'd1);
        rd(2'd3, 5'd0);
        rd(2'd0, 5'd0);

        // partial pixel discarded by rx_start
        send_byte(8'hD0, 1'b0);
        send_byte(8'hD1, 1'b0);
        send_byte(8'hD2, 1'b0);
        send_byte(8'hD3, 1'b0);
        send_frame(4, 1'b1);
        rd(2'd3, 5'd0);
        rd(2'd0, 5'd0);
        chk("restart R", 32'(data1[23:16]), 32'(gm(8'h11)));
        for (int r = 0; r < 4; r++)
            for (int a = 0; a < 5; a++) rd(2'(r), 5'(a));

        // out-of-range columns and row toggling with nothing pending
        for (int a = 5; a < 32; a++) rd(2'(a % 4), 5'(a));

        send_frame(5, 1'b0);
        rd(2'd3, 5'd0);
        rd(2'd0, 5'd0);
`ifdef MATRIX_FB_GAMMA_EN
        chk("gamma R", 32'(data1[23:16]), 32'd56);
`else
        chk("gamma R", 32'(data1[23:16]), 32'd128);
`endif

        // reset mid-frame: bank 0 shown afterwards, including its written pixel 0
        send_byte(8'h21, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h23, 1'b0);
        send_byte(8'h24, 1'b0);
        send_byte(8'h25, 1'b0);
        reset = 1'b1;
        tick; tick;
        chk("mid reset rx_ready", 32'(rx_ready), 32'd0);
        chk("mid reset data1", 32'(data1), 32'd0);
        reset = 1'b0;
        model_reset;
        rd(2'd0, 5'd0);
        rd(2'd0, 5'd1);
        send_byte(8'h31, 1'b0);
        send_byte(8'h32, 1'b0);
        send_byte(8'h33, 1'b0);
        rd(2'd0, 5'd0);
        rd(2'd1, 5'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
